// File: rtl/window_line_buffer.sv
// Purpose: turns a raster pixel stream into 3x3 interior windows using two line memories.
// Latency: a window appears one cycle after its bottom-right (newest) pixel is accepted.
// Backpressure: an un-consumed window stalls input (pixel_ready low) and is held stable.
//
// Ports:
//   clk, rst      - sole clock (rising edge); asynchronous active-high reset
//   pixel_in      - raster-order pixel, qualified by pixel_valid / pixel_ready
//   window_out    - 3x3 window, element e=3*r+c at [DATA_WIDTH*e +: DATA_WIDTH],
//                   r=0 oldest row, c=0 oldest column, e=8 newest pixel
//   window_valid  - window_out holds a complete interior window, consumed on window_ready
//   frame_done    - one-cycle pulse after the last pixel of a frame is accepted
module window_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic                    frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // One vertical slice of the window: top = two rows back, bot = current row.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] top;
        logic [DATA_WIDTH-1:0] mid;
        logic [DATA_WIDTH-1:0] bot;
    } column_t;

    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic [DATA_WIDTH-1:0]   line1 [IMG_WIDTH];   // previous row
    logic [DATA_WIDTH-1:0]   line2 [IMG_WIDTH];   // row before that
    logic [9*DATA_WIDTH-1:0] win_q;
    logic [9*DATA_WIDTH-1:0] win_next;
    column_t                 new_col;
    logic                    accept;
    logic                    col_last;
    logic                    row_last;
    logic                    interior;

    assign pixel_ready = !rst && (!window_valid || window_ready);
    assign accept      = pixel_valid && pixel_ready;
    assign col_last    = (col == COL_LAST);
    assign row_last    = (row == ROW_LAST);
    // Rows 0/1 and cols 0/1 would pull in stale line-memory data or wrap
    // across a row boundary, so only these positions complete a window.
    assign interior    = (row >= ROW_TWO) && (col >= COL_TWO);
    assign window_out  = win_q;

    always_comb begin
        new_col.top = line2[col];
        new_col.mid = line1[col];
        new_col.bot = pixel_in;
    end

    // Shift every row one column left and insert the new column on the right.
    always_comb begin
        win_next = win_q;
        for (int r = 0; r < 3; r++) begin
            win_next[DATA_WIDTH*(3*r+0) +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
            win_next[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
        end
        win_next[DATA_WIDTH*2 +: DATA_WIDTH] = new_col.top;
        win_next[DATA_WIDTH*5 +: DATA_WIDTH] = new_col.mid;
        win_next[DATA_WIDTH*8 +: DATA_WIDTH] = new_col.bot;
    end

    // Position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line memories carry no reset: stale contents are never read into a
    // valid window because windows need rows >= 2 of the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= pixel_in;
        end
    end

    // Window registers and output handshake. Accept implies the current
    // window is either invalid or being consumed, so overwriting is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q        <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                win_q        <= win_next;
                window_valid <= interior;
            end else if (window_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

endmodule
